// File: rtl/aes_pkg.sv
// Shared AES types and constants for the iterative MixColumns datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef logic [7:0] aes_byte_t;

  // Index 3 is row 0 so a column maps MSB-first onto the 128-bit bus.
  typedef aes_byte_t [3:0] column_t;

  // Index 3 is column 0, matching the in_data byte order.
  typedef column_t [3:0] state_t;

  localparam aes_byte_t AES_POLY = 8'h1b;

endpackage

// File: rtl/mix_column_comb.sv
// Combinational single-column MixColumns / InvMixColumns.
module mix_column_comb
  import aes_pkg::*;
(
  input  column_t    col_i,
  input  logic       inv_i,
  output column_t    col_o
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t u1, u, v1, v;
  aes_byte_t p0, p1, p2, p3;
  aes_byte_t t;
  aes_byte_t x01, x12, x23, x30;

  assign a0 = col_i[3];
  assign a1 = col_i[2];
  assign a2 = col_i[1];
  assign a3 = col_i[0];

  // Inverse = forward applied after folding in 4*(a0^a2) / 4*(a1^a3).
  xtime u_xu1 (.a(a0 ^ a2), .y(u1));
  xtime u_xu2 (.a(u1),      .y(u));
  xtime u_xv1 (.a(a1 ^ a3), .y(v1));
  xtime u_xv2 (.a(v1),      .y(v));

  assign p0 = inv_i ? (a0 ^ u) : a0;
  assign p1 = inv_i ? (a1 ^ v) : a1;
  assign p2 = inv_i ? (a2 ^ u) : a2;
  assign p3 = inv_i ? (a3 ^ v) : a3;

  assign t = p0 ^ p1 ^ p2 ^ p3;

  xtime u_x01 (.a(p0 ^ p1), .y(x01));
  xtime u_x12 (.a(p1 ^ p2), .y(x12));
  xtime u_x23 (.a(p2 ^ p3), .y(x23));
  xtime u_x30 (.a(p3 ^ p0), .y(x30));

  assign col_o = {p0 ^ t ^ x01, p1 ^ t ^ x12, p2 ^ t ^ x23, p3 ^ t ^ x30};

endmodule

// File: rtl/xtime.sv
// GF(2^8) multiply-by-two, reduced modulo x^8+x^4+x^3+x+1.
module xtime
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns: one column per cycle through a shared column unit,
// with valid/ready handshakes on both sides.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_e     fsm_q, fsm_d;
  logic [1:0] cnt_q, cnt_d;
  state_t     data_q, data_d;
  logic       inv_q, inv_d;

  column_t    col_in, col_out;

  // Column c lives at packed index 3-c, which for two bits is ~c.
  assign col_in = data_q[~cnt_q];

  mix_column_comb u_col (
    .col_i (col_in),
    .inv_i (inv_q),
    .col_o (col_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          data_d = in_data;
          inv_d  = in_inv;
          cnt_d  = 2'd0;
          fsm_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        data_d[~cnt_q] = col_out;
        cnt_d          = cnt_q + 2'd1;
        if (cnt_q == 2'd3) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      cnt_q  <= 2'd0;
      data_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      inv_q  <= inv_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter: known vectors, latency, backpressure,
// mid-operation reset and a random forward/inverse round trip.
module tb_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_C = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] VEC_D = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] ONE   = 128'd1;
  localparam logic [127:0] ZERO  = 128'd0;

  mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then performs one input handshake.
  task automatic send(input logic [127:0] d, input logic inv);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("accept_ready", {127'd0, in_ready}, ONE);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_inv   = ~inv;
  endtask

  // out_valid must be low after edges k+1..k+3 and high after k+4.
  task automatic await_result(input string tag, input logic [127:0] exp);
    tick();
    check({tag, "_busy_ready"}, {127'd0, in_ready}, ZERO);
    tick();
    tick();
    check({tag, "_early"}, {127'd0, out_valid}, ZERO);
    tick();
    check({tag, "_valid"}, {127'd0, out_valid}, ONE);
    check({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    logic [127:0] orig;
    logic [127:0] fwd;
    logic         seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;

    tick();
    check("rst_in_ready", {127'd0, in_ready}, ZERO);
    check("rst_out_valid", {127'd0, out_valid}, ZERO);
    check("rst_out_data", out_data, ZERO);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {127'd0, in_ready}, ONE);

    // Known vectors, forward and inverse; inputs toggle while busy.
    send(VEC_A, 1'b0);
    await_result("fwd_a", VEC_B);
    tick();
    check("fwd_a_idle", {127'd0, in_ready}, ONE);

    send(VEC_B, 1'b1);
    await_result("inv_b", VEC_A);
    tick();

    send(VEC_C, 1'b0);
    await_result("fwd_c", VEC_D);
    tick();

    send(VEC_D, 1'b1);
    await_result("inv_d", VEC_C);
    tick();

    // Backpressure: hold DONE for 10 cycles and poke in_valid meanwhile.
    out_ready = 1'b0;
    send(VEC_A, 1'b0);
    await_result("bp", VEC_B);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      in_data  = VEC_C;
      tick();
      check("bp_stable", out_data, VEC_B);
      check("bp_in_ready", {127'd0, in_ready}, ZERO);
      check("bp_out_valid", {127'd0, out_valid}, ONE);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", {127'd0, in_ready}, ONE);
    check("bp_release_valid", {127'd0, out_valid}, ZERO);
    check("bp_release_data", out_data, VEC_B);

    // Reset on the second BUSY cycle discards the operation.
    send(VEC_C, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_out_valid", {127'd0, out_valid}, ZERO);
    check("midrst_out_data", out_data, ZERO);
    check("midrst_in_ready", {127'd0, in_ready}, ZERO);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    check("midrst_no_output", {127'd0, seen_valid}, ZERO);
    check("midrst_idle", {127'd0, in_ready}, ONE);

    // Random round trip: forward then inverse must recover the original.
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(orig, 1'b0);
      tick();
      tick();
      tick();
      check("rt_fwd_early", {127'd0, out_valid}, ZERO);
      tick();
      check("rt_fwd_valid", {127'd0, out_valid}, ONE);
      fwd = out_data;
      tick();
      send(fwd, 1'b1);
      await_result("rt_inv", orig);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
